ins_prefetch: RTL

Instruction fetch stage with a prefetch buffer, sitting directly upstream of the execute datapath (register file, control, data memory). It holds the program in an internal instruction memory and runs a fetch program counter. Fetched 8-bit instruction codes go into a small FIFO and are presented to the consumer with a valid/ready handshake. A redirect port flushes the buffer and restarts fetch at a new address.

---
 rtl/ins_prefetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/ins_prefetch.sv
// ins_prefetch: instruction fetch stage with a prefetch FIFO.
// Holds the program in a synchronous-read instruction memory, runs a fetch PC,
// buffers fetched {code, pc} pairs and presents them on a valid/ready handshake.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   prog_we/addr/data    - program-load write port (active at any time)
//   ins_code, pc_out     - FIFO head instruction and its PC (0 when empty)
//   ins_valid, ins_ready - head handshake
//   redirect, redirect_pc - flush buffer and restart fetch at redirect_pc
module ins_prefetch #(
    parameter int DEPTH     = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] ins_code,
    output logic       ins_valid,
    input  logic       ins_ready,
    output logic [7:0] pc_out,
    input  logic       redirect,
    input  logic [7:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [MEM_DEPTH];
    logic [7:0]    code_buf [DEPTH];
    logic [7:0]    pc_buf [DEPTH];

    logic [7:0]    fetch_pc;
    logic          inflight;
    logic [7:0]    mem_q;
    logic [7:0]    q_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          issue;
    logic          push;
    logic          pop;

    // Issue only if the FIFO still has room for everything already in flight,
    // so the FIFO can never overflow.
    always_comb begin
        issue = (count + CW'(inflight)) < CW'(DEPTH);
        push  = inflight && !reset && !redirect;
        pop   = ins_valid && ins_ready;
    end

    // Read-first memory: the fetch path reads mem with the pre-edge contents.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            code_buf[wr_ptr] <= mem_q;
            pc_buf[wr_ptr]   <= q_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= 8'h00;
            inflight <= 1'b0;
            mem_q    <= 8'h00;
            q_pc     <= 8'h00;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            // Flush wins over any same-edge pop or push.
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                mem_q    <= mem[fetch_pc];
                q_pc     <= fetch_pc;
                inflight <= 1'b1;
                fetch_pc <= fetch_pc + 8'd1;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        ins_valid = (count != '0);
        ins_code  = ins_valid ? code_buf[rd_ptr] : 8'h00;
        pc_out    = ins_valid ? pc_buf[rd_ptr] : 8'h00;
    end

endmodule
